// File: rtl/mwc_wr_pack_if.sv
// ============================================================================
// Module      : mwc_wr_pack_if
// Description : Bus bundle for the write-data packer. It carries the NoC
//               input beat handshake and the packed-line write request
//               handshake towards mwc_cntl.
//               slave  : packer view (consumes in_*, produces out_*)
//               master : environment view (drives in_*, consumes out_*)
//               Optional stat_lines/stat_pkts exist only when
//               MWC_WR_PACK_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mwc_wr_pack_if #(
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 16,
   parameter int CHAN_W     = 2,
   parameter int BANK_W     = 3,
   parameter int PAGE_W     = 12,
   parameter int WORD_W     = 7
);
   // input beat side
   logic                         in_valid;
   logic                         in_ready;
   logic [1:0]                   in_cntl;
   logic [DATA_W-1:0]            in_data;
   // write request side
   logic                         out_valid;
   logic                         out_ready;
   logic [1:0]                   out_cntl;
   logic [CHAN_W-1:0]            out_chan;
   logic [BANK_W-1:0]            out_bank;
   logic [PAGE_W-1:0]            out_page;
   logic [WORD_W-1:0]            out_word;
   logic [LINE_WORDS*DATA_W-1:0] out_data;
   logic [LINE_WORDS-1:0]        out_mask;
   logic                         proto_err;
`ifdef MWC_WR_PACK_STATS_EN
   logic [31:0]                  stat_lines;
   logic [15:0]                  stat_pkts;
`endif

   modport slave (
      input  in_valid, in_cntl, in_data, out_ready,
      output in_ready, out_valid, out_cntl, out_chan, out_bank, out_page,
             out_word, out_data, out_mask, proto_err
`ifdef MWC_WR_PACK_STATS_EN
      , output stat_lines, stat_pkts
`endif
   );

   modport master (
      output in_valid, in_cntl, in_data, out_ready,
      input  in_ready, out_valid, out_cntl, out_chan, out_bank, out_page,
             out_word, out_data, out_mask, proto_err
`ifdef MWC_WR_PACK_STATS_EN
      , input stat_lines, stat_pkts
`endif
   );
endinterface

`default_nettype wire

// File: rtl/mwc_wr_pack.sv
// ============================================================================
// Module      : mwc_wr_pack
// Description : Write-data packer upstream of mwc_cntl. Takes NoC write
//               packets (one SOP address beat, then MOP/EOP data beats) and
//               packs the words into line-sized write requests with a
//               word-valid mask and an auto-incrementing DRAM address.
//               Two line buffers: the fill buffer and the registered output
//               stage, so input keeps flowing while downstream stalls.
// Ports       : clk             - rising-edge clock
//               reset_poweron_n - asynchronous active-low reset
//               bus             - mwc_wr_pack_if.slave (in_* beat handshake,
//                                 out_* line request, sticky proto_err)
// Options     : MWC_WR_PACK_STATS_EN adds stat_lines / stat_pkts counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mwc_wr_pack #(
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 16,
   parameter int CHAN_W     = 2,
   parameter int BANK_W     = 3,
   parameter int PAGE_W     = 12,
   parameter int WORD_W     = 7
) (
   input wire logic     clk,
   input wire logic     reset_poweron_n,
   mwc_wr_pack_if.slave bus
);
   localparam int PTR_W = $clog2(LINE_WORDS);
   localparam logic [PTR_W-1:0]  c_last_slot  = PTR_W'(LINE_WORDS - 1);
   localparam logic [WORD_W:0]   c_line_step  = (WORD_W + 1)'(LINE_WORDS);
   localparam logic [1:0]        c_cntl_sop   = 2'b01;
   localparam logic [1:0]        c_cntl_eop   = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // fill buffer
   logic [LINE_WORDS*DATA_W-1:0] r_fb_data;
   logic [LINE_WORDS-1:0]        r_fb_mask;
   logic                         r_fb_full;
   logic [1:0]                   r_fb_cntl;
   logic [CHAN_W-1:0]            r_fb_chan;
   logic [BANK_W-1:0]            r_fb_bank;
   logic [PAGE_W-1:0]            r_fb_page;
   logic [WORD_W-1:0]            r_fb_word;
   logic [PTR_W-1:0]             r_wptr;

   // address of the line currently being filled
   logic [CHAN_W-1:0]            r_cur_chan;
   logic [BANK_W-1:0]            r_cur_bank;
   logic [PAGE_W-1:0]            r_cur_page;
   logic [WORD_W-1:0]            r_cur_word;
   logic                         r_first;

   // output stage (second buffer)
   logic                         r_out_valid;
   logic [1:0]                   r_out_cntl;
   logic [CHAN_W-1:0]            r_out_chan;
   logic [BANK_W-1:0]            r_out_bank;
   logic [PAGE_W-1:0]            r_out_page;
   logic [WORD_W-1:0]            r_out_word;
   logic [LINE_WORDS*DATA_W-1:0] r_out_data;
   logic [LINE_WORDS-1:0]        r_out_mask;
   logic                         r_proto_err;

   logic w_fire;
   logic w_is_sop;
   logic w_is_eop;
   logic w_out_free;
   logic w_sop_beat;
   logic w_data_beat;
   logic w_stray;
   logic w_close;
   logic w_close_last;

   logic [LINE_WORDS*DATA_W-1:0] w_line_data;
   logic [LINE_WORDS-1:0]        w_line_mask;

   logic [WORD_W-1:0]            w_sop_word;
   logic [WORD_W-1:0]            w_sop_word_al;
   logic                         w_sop_misalign;
   logic [PAGE_W-1:0]            w_sop_page;
   logic [BANK_W-1:0]            w_sop_bank;
   logic [CHAN_W-1:0]            w_sop_chan;
   logic [WORD_W:0]              w_word_sum;
   logic [WORD_W-1:0]            w_next_word;
   logic [PAGE_W-1:0]            w_next_page;

   // The fill buffer is only ever left full while the output stage holds a
   // line, so "fill full" is exactly "both buffers full". Being purely
   // registered, this keeps out_ready away from in_ready.
   assign bus.in_ready = !r_fb_full;

   assign w_fire     = bus.in_valid && !r_fb_full;
   assign w_is_sop   = (bus.in_cntl == c_cntl_sop);
   assign w_is_eop   = (bus.in_cntl == c_cntl_eop);
   assign w_out_free = !r_out_valid || bus.out_ready;

   // SOP address fields: {chan, bank, page, word} packed in the LSBs
   assign w_sop_word     = bus.in_data[WORD_W-1:0];
   assign w_sop_page     = bus.in_data[WORD_W +: PAGE_W];
   assign w_sop_bank     = bus.in_data[WORD_W+PAGE_W +: BANK_W];
   assign w_sop_chan     = bus.in_data[WORD_W+PAGE_W+BANK_W +: CHAN_W];
   assign w_sop_misalign = |w_sop_word[PTR_W-1:0];
   assign w_sop_word_al  = {w_sop_word[WORD_W-1:PTR_W], {PTR_W{1'b0}}};

   // next line address: word wraps into the page, page wraps on its own
   assign w_word_sum  = {1'b0, r_cur_word} + c_line_step;
   assign w_next_word = w_word_sum[WORD_W-1:0];
   assign w_next_page = r_cur_page + PAGE_W'(w_word_sum[WORD_W]);

   // Closing line as it will look after this cycle: the fill buffer plus the
   // data beat being accepted now. Unwritten words read as zero.
   for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
      logic w_hit;
      assign w_hit = w_data_beat && (r_wptr == PTR_W'(gi));
      assign w_line_mask[gi] = r_fb_mask[gi] || w_hit;
      assign w_line_data[gi*DATA_W +: DATA_W] =
         w_hit        ? bus.in_data :
         r_fb_mask[gi] ? r_fb_data[gi*DATA_W +: DATA_W] : {DATA_W{1'b0}};
   end

   always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sop_beat   = 1'b0;
      w_data_beat  = 1'b0;
      w_stray      = 1'b0;
      w_close      = 1'b0;
      w_close_last = 1'b0;
      if (w_fire) begin
         case (r_state)
            ST_IDLE: begin
               if (w_is_sop) begin
                  w_sop_beat  = 1'b1;
                  w_state_nxt = ST_DATA;
               end else begin
                  w_stray = 1'b1;
               end
            end
            ST_DATA: begin
               if (w_is_sop) begin
                  // early SOP: flush any partial line as the packet's last
                  w_sop_beat   = 1'b1;
                  w_close      = (r_wptr != '0);
                  w_close_last = 1'b1;
               end else begin
                  w_data_beat  = 1'b1;
                  w_close      = w_is_eop || (r_wptr == c_last_slot);
                  w_close_last = w_is_eop;
                  if (w_is_eop) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
         r_fb_data   <= '0;
         r_fb_mask   <= '0;
         r_fb_full   <= 1'b0;
         r_fb_cntl   <= '0;
         r_fb_chan   <= '0;
         r_fb_bank   <= '0;
         r_fb_page   <= '0;
         r_fb_word   <= '0;
         r_wptr      <= '0;
         r_cur_chan  <= '0;
         r_cur_bank  <= '0;
         r_cur_page  <= '0;
         r_cur_word  <= '0;
         r_first     <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_cntl  <= '0;
         r_out_chan  <= '0;
         r_out_bank  <= '0;
         r_out_page  <= '0;
         r_out_word  <= '0;
         r_out_data  <= '0;
         r_out_mask  <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_sop_beat) begin
            r_wptr <= '0;
         end else if (w_data_beat) begin
            r_wptr <= w_close ? '0 : r_wptr + 1'b1;
         end

         if (w_data_beat && !w_close) begin
            r_fb_data[r_wptr*DATA_W +: DATA_W] <= bus.in_data;
            r_fb_mask[r_wptr]                  <= 1'b1;
         end

         if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         // A waiting full line has priority for the output stage; input is
         // stalled meanwhile, so no line can close in the same cycle.
         if (r_fb_full && w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_cntl  <= r_fb_cntl;
            r_out_chan  <= r_fb_chan;
            r_out_bank  <= r_fb_bank;
            r_out_page  <= r_fb_page;
            r_out_word  <= r_fb_word;
            r_out_data  <= r_fb_data;
            r_out_mask  <= r_fb_mask;
            r_fb_full   <= 1'b0;
            r_fb_mask   <= '0;
         end else if (w_close) begin
            if (w_out_free) begin
               r_out_valid <= 1'b1;
               r_out_cntl  <= {w_close_last, r_first};
               r_out_chan  <= r_cur_chan;
               r_out_bank  <= r_cur_bank;
               r_out_page  <= r_cur_page;
               r_out_word  <= r_cur_word;
               r_out_data  <= w_line_data;
               r_out_mask  <= w_line_mask;
               r_fb_mask   <= '0;
            end else begin
               r_fb_full   <= 1'b1;
               r_fb_cntl   <= {w_close_last, r_first};
               r_fb_chan   <= r_cur_chan;
               r_fb_bank   <= r_cur_bank;
               r_fb_page   <= r_cur_page;
               r_fb_word   <= r_cur_word;
               r_fb_data   <= w_line_data;
               r_fb_mask   <= w_line_mask;
            end
         end

         if (w_close) begin
            r_cur_word <= w_next_word;
            r_cur_page <= w_next_page;
            r_first    <= 1'b0;
         end

         // a new SOP overrides the advanced address of a flushed line
         if (w_sop_beat) begin
            r_cur_chan <= w_sop_chan;
            r_cur_bank <= w_sop_bank;
            r_cur_page <= w_sop_page;
            r_cur_word <= w_sop_word_al;
            r_first    <= 1'b1;
         end

         if (w_stray || (w_sop_beat && ((r_state == ST_DATA) || w_sop_misalign))) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_cntl  = r_out_cntl;
   assign bus.out_chan  = r_out_chan;
   assign bus.out_bank  = r_out_bank;
   assign bus.out_page  = r_out_page;
   assign bus.out_word  = r_out_word;
   assign bus.out_data  = r_out_data;
   assign bus.out_mask  = r_out_mask;
   assign bus.proto_err = r_proto_err;

`ifdef MWC_WR_PACK_STATS_EN
   logic [31:0] r_stat_lines;
   logic [15:0] r_stat_pkts;

   always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
         r_stat_lines <= '0;
         r_stat_pkts  <= '0;
      end else if (r_out_valid && bus.out_ready) begin
         if (r_stat_lines != '1) begin
            r_stat_lines <= r_stat_lines + 1'b1;
         end
         if (r_out_cntl[1] && (r_stat_pkts != '1)) begin
            r_stat_pkts <= r_stat_pkts + 1'b1;
         end
      end
   end

   assign bus.stat_lines = r_stat_lines;
   assign bus.stat_pkts  = r_stat_pkts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mwc_wr_pack.sv
// ============================================================================
// Module      : tb_mwc_wr_pack
// Description : Directed self-checking bench for mwc_wr_pack. Each task drives
//               one scenario and checks hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mwc_wr_pack;
   localparam int DATA_W     = 32;
   localparam int LINE_WORDS = 16;
   localparam logic [1:0] C_SOP = 2'b01;
   localparam logic [1:0] C_MOP = 2'b00;
   localparam logic [1:0] C_EOP = 2'b10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vecs  = 0;
   int   errs  = 0;

   always #5 clk = ~clk;

   mwc_wr_pack_if #(.DATA_W(32), .LINE_WORDS(16), .CHAN_W(2), .BANK_W(3),
                    .PAGE_W(12), .WORD_W(7)) b ();

   mwc_wr_pack #(.DATA_W(32), .LINE_WORDS(16), .CHAN_W(2), .BANK_W(3),
                 .PAGE_W(12), .WORD_W(7)) u_dut (
      .clk             (clk),
      .reset_poweron_n (rst_n),
      .bus             (b)
   );

   typedef struct {
      logic [1:0]   cntl;
      logic [1:0]   chan;
      logic [2:0]   bank;
      logic [11:0]  page;
      logic [6:0]   word;
      logic [511:0] data;
      logic [15:0]  mask;
   } line_t;

   line_t lines[$];

   // record every line the downstream side accepts
   always @(negedge clk) begin : mon
      line_t l;
      if (rst_n && b.out_valid && b.out_ready) begin
         l.cntl = b.out_cntl;
         l.chan = b.out_chan;
         l.bank = b.out_bank;
         l.page = b.out_page;
         l.word = b.out_word;
         l.data = b.out_data;
         l.mask = b.out_mask;
         lines.push_back(l);
      end
   end

   function automatic logic [31:0] addr(input int ch, input int bk, input int pg, input int w);
      return (32'(ch) << 22) | (32'(bk) << 19) | (32'(pg) << 7) | 32'(w);
   endfunction

   // drive one beat; returns at posedge+1 of the accepting edge
   task automatic send_beat(input logic [1:0] c, input logic [31:0] d);
      logic rdy;
      int   n;
      n = 0;
      b.in_valid = 1'b1;
      b.in_cntl  = c;
      b.in_data  = d;
      do begin
         @(negedge clk);
         rdy = b.in_ready;
         n++;
         @(posedge clk);
         #1;
      end while (!rdy && n < 300);
      b.in_valid = 1'b0;
      if (!rdy) begin
         errs++;
         $display("FAIL send_beat timeout: in_ready stuck at 0, required 1");
      end
   endtask

   task automatic wait_lines(input int n);
      int k;
      k = 0;
      while (lines.size() < n && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      if (lines.size() < n) begin
         errs++;
         $display("FAIL wait_lines timeout: got %0d lines, required %0d", lines.size(), n);
      end
   endtask

   task automatic apply_reset();
      b.in_valid = 1'b0;
      b.in_cntl  = 2'b00;
      b.in_data  = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      lines.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      vecs++; if (b.in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready: got %b want 1", b.in_ready); end
      vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid: got %b want 0", b.out_valid); end
      vecs++; if (b.proto_err !== 1'b0) begin errs++; $display("FAIL reset proto_err: got %b want 0", b.proto_err); end
      vecs++;
      if (b.out_cntl !== 2'b00 || b.out_mask !== 16'h0 || b.out_word !== 7'd0 || b.out_data !== '0) begin
         errs++;
         $display("FAIL reset out fields: cntl %b mask %h word %0d, want all zero", b.out_cntl, b.out_mask, b.out_word);
      end
   endtask

   task automatic test_single_line();
      line_t l;
      logic  bad;
      lines.delete();
      b.out_ready = 1'b1;
      send_beat(C_SOP, addr(1, 2, 5, 0));
      for (int i = 0; i < 15; i++) send_beat(C_MOP, 32'(i));
      vecs++; if (b.out_valid !== 1'b0) begin errs++; $display("FAIL single early out_valid: got %b want 0", b.out_valid); end
      send_beat(C_EOP, 32'd15);
      vecs++; if (b.out_valid !== 1'b1) begin errs++; $display("FAIL single latency out_valid: got %b want 1", b.out_valid); end
      wait_lines(1);
      if (lines.size() >= 1) begin
         l = lines[0];
         vecs++;
         if (l.cntl !== 2'b11 || l.mask !== 16'hFFFF || l.word !== 7'd0 || l.page !== 12'd5 ||
             l.bank !== 3'd2 || l.chan !== 2'd1) begin
            errs++;
            $display("FAIL single fields: cntl %b mask %h ch %0d bk %0d pg %0d w %0d, want 11 ffff 1 2 5 0",
                     l.cntl, l.mask, l.chan, l.bank, l.page, l.word);
         end
         bad = 1'b0;
         for (int j = 0; j < 16; j++) if (l.data[j*32 +: 32] !== 32'(j)) bad = 1'b1;
         vecs++; if (bad) begin errs++; $display("FAIL single data: got %h, want words 0..15", l.data); end
      end
      vecs++; if (lines.size() !== 1) begin errs++; $display("FAIL single count: got %0d want 1", lines.size()); end
   endtask

   task automatic test_multi_line();
      int         ew[3];
      int         ep[3];
      logic [1:0] ec[3];
      logic [15:0] em[3];
      line_t      l;
      logic       bad;
      ew = '{112, 0, 16};
      ep = '{5, 6, 6};
      ec = '{2'b01, 2'b00, 2'b10};
      em = '{16'hFFFF, 16'hFFFF, 16'h00FF};
      lines.delete();
      b.out_ready = 1'b1;
      send_beat(C_SOP, addr(1, 2, 5, 112));
      for (int i = 0; i < 40; i++) send_beat((i == 39) ? C_EOP : C_MOP, 32'(100 + i));
      wait_lines(3);
      vecs++; if (lines.size() !== 3) begin errs++; $display("FAIL multi count: got %0d want 3", lines.size()); end
      for (int k = 0; k < 3 && k < lines.size(); k++) begin
         l = lines[k];
         vecs++;
         if (l.word !== 7'(ew[k]) || l.page !== 12'(ep[k]) || l.cntl !== ec[k] || l.mask !== em[k]) begin
            errs++;
            $display("FAIL multi line%0d: w %0d pg %0d cntl %b mask %h, want w %0d pg %0d cntl %b mask %h",
                     k, l.word, l.page, l.cntl, l.mask, ew[k], ep[k], ec[k], em[k]);
         end
         bad = 1'b0;
         for (int j = 0; j < 16; j++)
            if (em[k][j] && l.data[j*32 +: 32] !== 32'(100 + 16*k + j)) bad = 1'b1;
         vecs++; if (bad) begin errs++; $display("FAIL multi data line%0d: got %h", k, l.data); end
      end
      vecs++; if (b.proto_err !== 1'b0) begin errs++; $display("FAIL multi proto_err: got %b want 0", b.proto_err); end
   endtask

   task automatic test_backpressure();
      line_t l;
      int    ew[3];
      logic [1:0] ec[3];
      ew = '{32, 48, 64};
      ec = '{2'b01, 2'b00, 2'b10};
      lines.delete();
      b.out_ready = 1'b0;
      send_beat(C_SOP, addr(0, 1, 10, 32));
      for (int i = 0; i < 31; i++) send_beat(C_MOP, 32'(200 + i));
      vecs++; if (b.in_ready !== 1'b1) begin errs++; $display("FAIL bp in_ready@31: got %b want 1", b.in_ready); end
      send_beat(C_MOP, 32'd231);
      vecs++; if (b.in_ready !== 1'b0) begin errs++; $display("FAIL bp in_ready@32: got %b want 0", b.in_ready); end
      repeat (5) @(posedge clk);
      #1;
      vecs++; if (b.in_ready !== 1'b0) begin errs++; $display("FAIL bp in_ready held: got %b want 0", b.in_ready); end
      vecs++;
      if (b.out_valid !== 1'b1 || b.out_data[31:0] !== 32'd200 || b.out_data[511:480] !== 32'd215 ||
          b.out_word !== 7'd32 || b.out_cntl !== 2'b01) begin
         errs++;
         $display("FAIL bp held line: valid %b w0 %0d w15 %0d word %0d cntl %b, want 1 200 215 32 01",
                  b.out_valid, b.out_data[31:0], b.out_data[511:480], b.out_word, b.out_cntl);
      end
      fork
         begin
            for (int i = 32; i < 48; i++) send_beat((i == 47) ? C_EOP : C_MOP, 32'(200 + i));
         end
         begin
            repeat (4) @(posedge clk);
            #1 b.out_ready = 1'b1;
         end
      join
      wait_lines(3);
      vecs++; if (lines.size() !== 3) begin errs++; $display("FAIL bp count: got %0d want 3", lines.size()); end
      for (int k = 0; k < 3 && k < lines.size(); k++) begin
         l = lines[k];
         vecs++;
         if (l.word !== 7'(ew[k]) || l.cntl !== ec[k] || l.mask !== 16'hFFFF || l.page !== 12'd10 ||
             l.data[31:0] !== 32'(200 + 16*k) || l.data[511:480] !== 32'(215 + 16*k)) begin
            errs++;
            $display("FAIL bp line%0d: w %0d cntl %b mask %h first %0d last %0d, want w %0d cntl %b ffff %0d %0d",
                     k, l.word, l.cntl, l.mask, l.data[31:0], l.data[511:480], ew[k], ec[k],
                     200 + 16*k, 215 + 16*k);
         end
      end
   endtask

   task automatic test_sop_abort();
      line_t l;
      lines.delete();
      b.out_ready = 1'b1;
      send_beat(C_SOP, addr(2, 3, 7, 0));
      for (int i = 0; i < 5; i++) send_beat(C_MOP, 32'(300 + i));
      send_beat(C_SOP, addr(2, 3, 8, 0));
      vecs++; if (b.proto_err !== 1'b1) begin errs++; $display("FAIL abort proto_err: got %b want 1", b.proto_err); end
      wait_lines(1);
      if (lines.size() >= 1) begin
         l = lines[0];
         vecs++;
         if (l.mask !== 16'h001F || l.cntl !== 2'b11 || l.page !== 12'd7 || l.word !== 7'd0 ||
             l.data[159:128] !== 32'd304) begin
            errs++;
            $display("FAIL abort partial: mask %h cntl %b pg %0d w %0d d4 %0d, want 001f 11 7 0 304",
                     l.mask, l.cntl, l.page, l.word, l.data[159:128]);
         end
      end
      send_beat(C_MOP, 32'd400);
      send_beat(C_MOP, 32'd401);
      send_beat(C_EOP, 32'd402);
      wait_lines(2);
      vecs++; if (lines.size() !== 2) begin errs++; $display("FAIL abort count: got %0d want 2", lines.size()); end
      if (lines.size() >= 2) begin
         l = lines[1];
         vecs++;
         if (l.mask !== 16'h0007 || l.cntl !== 2'b11 || l.page !== 12'd8 || l.chan !== 2'd2 ||
             l.data[31:0] !== 32'd400 || l.data[95:64] !== 32'd402) begin
            errs++;
            $display("FAIL abort next pkt: mask %h cntl %b pg %0d ch %0d d0 %0d, want 0007 11 8 2 400",
                     l.mask, l.cntl, l.page, l.chan, l.data[31:0]);
         end
      end
   endtask

   task automatic test_idle_mop();
      line_t l;
      apply_reset();
      b.out_ready = 1'b1;
      vecs++; if (b.proto_err !== 1'b0) begin errs++; $display("FAIL idle proto_err cleared: got %b want 0", b.proto_err); end
      send_beat(C_MOP, 32'd77);
      repeat (3) @(posedge clk);
      #1;
      vecs++; if (b.proto_err !== 1'b1) begin errs++; $display("FAIL idle proto_err: got %b want 1", b.proto_err); end
      vecs++;
      if (lines.size() !== 0 || b.out_valid !== 1'b0) begin
         errs++;
         $display("FAIL idle stray output: lines %0d valid %b, want 0 0", lines.size(), b.out_valid);
      end
      send_beat(C_SOP, addr(3, 1, 9, 3));
      send_beat(C_MOP, 32'd500);
      send_beat(C_EOP, 32'd501);
      wait_lines(1);
      if (lines.size() >= 1) begin
         l = lines[0];
         vecs++;
         if (l.word !== 7'd0 || l.page !== 12'd9 || l.chan !== 2'd3 || l.bank !== 3'd1 ||
             l.mask !== 16'h0003 || l.cntl !== 2'b11 || l.data[63:32] !== 32'd501) begin
            errs++;
            $display("FAIL idle aligned line: w %0d pg %0d ch %0d bk %0d mask %h cntl %b, want 0 9 3 1 0003 11",
                     l.word, l.page, l.chan, l.bank, l.mask, l.cntl);
         end
      end
      vecs++; if (lines.size() !== 1) begin errs++; $display("FAIL idle count: got %0d want 1", lines.size()); end
   endtask

   task automatic test_reset_mid();
      line_t l;
      apply_reset();
      b.out_ready = 1'b0;
      send_beat(C_SOP, addr(1, 0, 3, 0));
      for (int i = 0; i < 23; i++) send_beat(C_MOP, 32'(600 + i));
      vecs++; if (b.out_valid !== 1'b1) begin errs++; $display("FAIL rstmid pre out_valid: got %b want 1", b.out_valid); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1 || b.out_mask !== 16'h0) begin
         errs++;
         $display("FAIL rstmid async: valid %b in_ready %b mask %h, want 0 1 0000", b.out_valid, b.in_ready, b.out_mask);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      lines.delete();
      b.out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      vecs++; if (lines.size() !== 0) begin errs++; $display("FAIL rstmid leftover: got %0d lines want 0", lines.size()); end
      send_beat(C_SOP, addr(0, 2, 4, 16));
      send_beat(C_MOP, 32'd700);
      send_beat(C_EOP, 32'd701);
      wait_lines(1);
      if (lines.size() >= 1) begin
         l = lines[0];
         vecs++;
         if (l.mask !== 16'h0003 || l.cntl !== 2'b11 || l.word !== 7'd16 || l.page !== 12'd4 ||
             l.data[31:0] !== 32'd700) begin
            errs++;
            $display("FAIL rstmid new pkt: mask %h cntl %b w %0d pg %0d d0 %0d, want 0003 11 16 4 700",
                     l.mask, l.cntl, l.word, l.page, l.data[31:0]);
         end
      end
   endtask

   initial begin
      b.in_valid  = 1'b0;
      b.in_cntl   = 2'b00;
      b.in_data   = '0;
      b.out_ready = 1'b1;
      test_reset();
      test_single_line();
      test_multi_line();
      test_backpressure();
      test_sop_abort();
      test_idle_mop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

`default_nettype wire

// File: doc/mwc_wr_pack.md
Name: mwc_wr_pack

Overview:
- Write-data packer sitting directly upstream of mwc_cntl, between the manager NoC data path and the main-memory write path.
- Consumes NoC write packets: one address beat, then one or more data beats.
- Packs the data words into DRAM-line-sized write requests, each with a word-valid mask and an auto-incrementing DRAM address.
- Two line buffers (ping-pong) let input continue while the downstream memory controller stalls.

Parameters:
- DATA_W, 32: bits per data word (one execution lane).
- LINE_WORDS, 16: words per write line; power of two, ≥2.
- CHAN_W, 2: DRAM channel address width.
- BANK_W, 3: DRAM bank address width.
- PAGE_W, 12: DRAM page address width.
- WORD_W, 7: DRAM word-in-page address width; 2^WORD_W must be a multiple of LINE_WORDS.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset_poweron_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_cntl  in  2  01=SOP (address beat), 00=MOP data, 10=EOP data, 11=reserved (treated as MOP).
- in_data  in  DATA_W  data word, or packed address {chan,bank,page,word} in LSBs on SOP.
- out_valid  out  1  write request valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_cntl  out  2  01=first line of packet, 10=last line, 11=single-line packet, 00=middle.
- out_chan  out  CHAN_W  DRAM channel.
- out_bank  out  BANK_W  DRAM bank.
- out_page  out  PAGE_W  DRAM page.
- out_word  out  WORD_W  DRAM word, always line-aligned.
- out_data  out  LINE_WORDS*DATA_W  line data; word i at bits [i*DATA_W +: DATA_W].
- out_mask  out  LINE_WORDS  bit i set = word i valid.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0 except in_ready=1.
  - FSM to IDLE, both buffers empty, write pointer 0.
  - Asserting reset mid-packet discards all buffered data; no partial line is emitted.
- FSM states:
  - IDLE: wait for SOP. An accepted SOP latches the address and goes to DATA. MOP/EOP beats accepted in IDLE are dropped and set proto_err.
  - DATA:
    - Each accepted data beat writes fill buffer slot wptr, sets mask bit wptr, and increments wptr.
    - When wptr reaches LINE_WORDS, or on an EOP beat, the fill buffer is marked full and handed to the output side; wptr returns to 0.
    - After the hand-off the line address advances by LINE_WORDS words: word wraps to 0 and page increments; page wraps to 0; bank and channel never change.
    - EOP returns to IDLE.
- SOP received while in DATA:
  - Any partial line is closed with the last-line marking and proto_err is set.
  - The new address is latched; the FSM stays in DATA.
  - If the partial line has zero words, nothing is emitted, and the previously emitted line is not retro-marked.
- A misaligned SOP word address has its low log2(LINE_WORDS) bits forced to 0 and sets proto_err.
- Marking rules:
  - First-line and last-line flags are computed per line.
  - An EOP beat landing exactly on slot LINE_WORDS-1 produces one full line marked last; no empty line follows.
- Buffering and in_ready:
  - in_ready = 0 only when both buffers are full; SOP beats also require a free fill buffer.
  - A buffer freed by out_ready and a new hand-off in the same cycle are both honoured.
  - No combinational path from out_ready to in_ready: the free status is registered, costing one bubble cycle.
- Output side:
  - out_* are registered.
  - The last accepted beat of a line at cycle T gives out_valid=1 at T+1 if the output buffer is free.
  - out_* stay stable while out_valid & !out_ready.
  - Buffers drain in fill order.
- proto_err clears only on reset.

Optional Feature:
- Macro: MWC_WR_PACK_STATS_EN.
- Defined: adds outputs stat_lines (32 bits) and stat_pkts (16 bits).
  - stat_lines increments on each out_valid & out_ready.
  - stat_pkts increments on each accepted line marked last.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- SOP addr {ch1,bk2,pg5,w0}, 16 MOP words 0..15 (last as EOP), out_ready=1 → one line, cntl=11, mask=0xFFFF, word=0, data words 0..15, out_valid the cycle after the EOP is accepted.
- SOP at pg5 w=112, 40 data beats → three lines: w112/pg5 cntl 01; w0/pg6 cntl 00; w16/pg6 cntl 10 with mask=0x00FF.
- out_ready held 0 while 48 beats stream → in_ready drops after the 32nd data beat, data is held stable; releasing out_ready drains all three lines in order with no loss.
- 5 data beats then a new SOP without EOP → line with mask=0x001F cntl 11, proto_err=1; the new packet proceeds normally.
- MOP beat in IDLE, then SOP with word=3 → proto_err=1, no output for the MOP, first line word=0.
- Reset pulsed low mid-packet with 7 words buffered → out_valid=0 immediately, no partial line after reset, in_ready=1.
